// File: rtl/csync_separator_if.sv
// Bus between a composite-sync source and the csync separator:
// csync in, recovered hsync/vsync plus lock status and learned timing out.
interface csync_separator_if #(
  parameter int CNT_W = 16
);
  logic             csync;
  logic             hsync;
  logic             vsync;
  logic             locked;
  logic [CNT_W-1:0] hs_len;
  logic [CNT_W-1:0] line_len;

  modport master (
    output csync,
    input  hsync, vsync, locked, hs_len, line_len
  );

  modport slave (
    input  csync,
    output hsync, vsync, locked, hs_len, line_len
  );
endinterface

// File: rtl/csync_separator.sv
// Composite-sync separator: learns pulse width and line period, locks onto
// stable timing, detects broad vsync pulses and flywheels hsync through them.
module csync_separator #(
  parameter int CNT_W = 16
) (
  input logic              clk_i,
  input logic              reset_i,
  csync_separator_if.slave bus_io
);

  localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] ONE        = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [2:0]       MATCH_FULL = 3'd4;

  logic             sync1_q, csync_q, prev_q;
  logic [CNT_W-1:0] run_cnt_q, run_cnt_d, per_cnt_q, per_cnt_d;
  logic [CNT_W-1:0] w_q, w_d, hs_ref_q, hs_ref_d, line_ref_q, line_ref_d;
  logic [CNT_W-1:0] line_cnt_q, line_cnt_d;
  logic [2:0]       match_q, match_d;
  logic             locked_q, locked_d, vsync_q, vsync_d;
  logic             hsync_q, hsync_d, skip_q, skip_d;

  logic             rise_s, fall_s, run_sat_s, match_s, long_run_s;
  logic [CNT_W:0]   thr_p1_s;

  function automatic logic within_one(input logic [CNT_W-1:0] a,
                                      input logic [CNT_W-1:0] b);
    logic [CNT_W-1:0] diff;
    diff = (a >= b) ? (a - b) : (b - a);
    return (diff <= ONE);
  endfunction

  assign rise_s     = csync_q & ~prev_q;
  assign fall_s     = ~csync_q & prev_q;
  assign run_sat_s  = (run_cnt_q == CNT_MAX);
  assign thr_p1_s   = {hs_ref_q, 1'b0} + {{CNT_W{1'b0}}, 1'b1};
  assign long_run_s = ({1'b0, run_cnt_q} == thr_p1_s);
  assign match_s    = within_one(per_cnt_q, line_ref_q) && within_one(w_q, hs_ref_q);

  // Next-state logic: run/period measurement, lock tracking, vsync and flywheel.
  always_comb begin
    run_cnt_d  = run_cnt_q;
    per_cnt_d  = per_cnt_q;
    w_d        = w_q;
    hs_ref_d   = hs_ref_q;
    line_ref_d = line_ref_q;
    match_d    = match_q;
    skip_d     = skip_q;
    line_cnt_d = line_cnt_q;

    if (rise_s || fall_s) begin
      run_cnt_d = ONE;
    end else if (!run_sat_s) begin
      run_cnt_d = run_cnt_q + ONE;
    end else begin
      run_cnt_d = run_cnt_q;
    end

    if (rise_s) begin
      per_cnt_d = ONE;
    end else if (per_cnt_q != CNT_MAX) begin
      per_cnt_d = per_cnt_q + ONE;
    end else begin
      per_cnt_d = per_cnt_q;
    end

    if (fall_s) begin
      w_d = run_cnt_q;
    end else begin
      w_d = w_q;
    end

    // Rises inside the vertical interval carry serrations, not line timing.
    if (rise_s && !vsync_q) begin
      skip_d = 1'b0;
      if (skip_q || (per_cnt_q == CNT_MAX) || (w_q == CNT_MAX)) begin
        match_d = match_q;
      end else if (match_s) begin
        match_d = (match_q == MATCH_FULL) ? MATCH_FULL : match_q + 3'd1;
      end else begin
        line_ref_d = per_cnt_q;
        hs_ref_d   = w_q;
        match_d    = 3'd0;
      end
    end else begin
      skip_d = skip_q;
    end

    if (run_sat_s) begin
      match_d = 3'd0;
    end else begin
      match_d = match_d;
    end

    locked_d = (match_d == MATCH_FULL);

    if (!locked_d) begin
      vsync_d = 1'b0;
    end else if (long_run_s) begin
      vsync_d = csync_q;
    end else begin
      vsync_d = vsync_q;
    end

    if (vsync_q && !vsync_d) begin
      skip_d = 1'b1;
    end else begin
      skip_d = skip_d;
    end

    if (rise_s && !vsync_q) begin
      line_cnt_d = '0;
    end else if (line_cnt_q >= (line_ref_q - ONE)) begin
      line_cnt_d = '0;
    end else begin
      line_cnt_d = line_cnt_q + ONE;
    end

    if (vsync_q) begin
      hsync_d = (line_cnt_d < hs_ref_q);
    end else begin
      hsync_d = csync_q;
    end
  end

  // State registers with synchronous reset, including the csync synchronizer.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      sync1_q    <= 1'b0;
      csync_q    <= 1'b0;
      prev_q     <= 1'b0;
      run_cnt_q  <= '0;
      per_cnt_q  <= '0;
      w_q        <= '0;
      hs_ref_q   <= '0;
      line_ref_q <= '0;
      line_cnt_q <= '0;
      match_q    <= 3'd0;
      locked_q   <= 1'b0;
      vsync_q    <= 1'b0;
      hsync_q    <= 1'b0;
      skip_q     <= 1'b1;
    end else begin
      sync1_q    <= bus_io.csync;
      csync_q    <= sync1_q;
      prev_q     <= csync_q;
      run_cnt_q  <= run_cnt_d;
      per_cnt_q  <= per_cnt_d;
      w_q        <= w_d;
      hs_ref_q   <= hs_ref_d;
      line_ref_q <= line_ref_d;
      line_cnt_q <= line_cnt_d;
      match_q    <= match_d;
      locked_q   <= locked_d;
      vsync_q    <= vsync_d;
      hsync_q    <= hsync_d;
      skip_q     <= skip_d;
    end
  end

  assign bus_io.hsync    = hsync_q;
  assign bus_io.vsync    = vsync_q;
  assign bus_io.locked   = locked_q;
  assign bus_io.hs_len   = hs_ref_q;
  assign bus_io.line_len = line_ref_q;

endmodule
